// File: rtl/seg7_scan_reader_pkg.sv
// Shared definitions for the seven-segment scan reader: segment table,
// FSM encoding and digit count.
package seg7_scan_reader_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low a..g patterns, indexed by the hex nibble they display
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_scan_reader_to_hex.sv
// Combinational seven-segment to hex decoder; patterns outside the table
// report valid=0.
module seg7_to_hex
  import seg7_scan_reader_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  // Exact-match lookup against the shared pattern table
  always_comb begin
    nibble = 4'd0;
    valid  = 1'b1;
    case (seg)
      SEG_TABLE[0]:  nibble = 4'h0;
      SEG_TABLE[1]:  nibble = 4'h1;
      SEG_TABLE[2]:  nibble = 4'h2;
      SEG_TABLE[3]:  nibble = 4'h3;
      SEG_TABLE[4]:  nibble = 4'h4;
      SEG_TABLE[5]:  nibble = 4'h5;
      SEG_TABLE[6]:  nibble = 4'h6;
      SEG_TABLE[7]:  nibble = 4'h7;
      SEG_TABLE[8]:  nibble = 4'h8;
      SEG_TABLE[9]:  nibble = 4'h9;
      SEG_TABLE[10]: nibble = 4'hA;
      SEG_TABLE[11]: nibble = 4'hB;
      SEG_TABLE[12]: nibble = 4'hC;
      SEG_TABLE[13]: nibble = 4'hD;
      SEG_TABLE[14]: nibble = 4'hE;
      SEG_TABLE[15]: nibble = 4'hF;
      default: begin
        nibble = 4'd0;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed six-digit seven-segment display bus, debounces each
// digit over CONFIRM identical decodes and reports completed frames.
module seg7_scan_reader
  import seg7_scan_reader_pkg::*;
#(
  parameter int CONFIRM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [5:0]  dig_sel,
  input  logic        seg_valid,
  output logic [23:0] digits,
  output logic [5:0]  digit_ok,
  output logic        frame_done,
  output logic        err_pattern,
  output logic        err_sel
);

  localparam logic [1:0] CONFIRM_C = 2'(CONFIRM);

  logic [3:0]  nibble_s;
  logic        pat_valid_s;
  logic        onehot_s;
  logic        sample_s;
  logic [5:0]  commit_s;
  logic [3:0]  cand_n_s [NUM_DIGITS];
  logic [1:0]  cnt_n_s  [NUM_DIGITS];
  logic [23:0] digits_n_s;
  logic [5:0]  ok_n_s;
  state_t      state_n_s;

  logic [3:0]  cand_r [NUM_DIGITS];
  logic [1:0]  cnt_r  [NUM_DIGITS];
  logic [23:0] digits_r;
  logic [5:0]  digit_ok_r;
  logic        frame_done_r;
  logic        err_pattern_r;
  logic        err_sel_r;
  state_t      state_r;

  seg7_to_hex u_dec (
    .seg    (seg_in),
    .nibble (nibble_s),
    .valid  (pat_valid_s)
  );

  // Per-digit confirmation: candidate/count update and commit detection
  always_comb begin
    onehot_s   = (dig_sel != 6'd0) && ((dig_sel & (dig_sel - 6'd1)) == 6'd0);
    sample_s   = seg_valid && onehot_s;
    commit_s   = 6'd0;
    digits_n_s = digits_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cand_n_s[i] = cand_r[i];
      cnt_n_s[i]  = cnt_r[i];
      if (sample_s && dig_sel[i]) begin
        if (!pat_valid_s) begin
          cnt_n_s[i] = 2'd0;
        end else if (nibble_s == cand_r[i]) begin
          cnt_n_s[i]  = (cnt_r[i] >= CONFIRM_C) ? CONFIRM_C : cnt_r[i] + 2'd1;
          commit_s[i] = (cnt_n_s[i] == CONFIRM_C);
        end else begin
          cand_n_s[i] = nibble_s;
          cnt_n_s[i]  = 2'd1;
          commit_s[i] = (CONFIRM_C == 2'd1);
        end
      end else begin
        cand_n_s[i] = cand_r[i];
        cnt_n_s[i]  = cnt_r[i];
      end
      digits_n_s[4*i +: 4] = commit_s[i] ? nibble_s : digits_r[4*i +: 4];
    end
    // Leaving DONE starts a fresh frame, but a commit in that cycle still counts
    ok_n_s = ((state_r == ST_DONE) ? 6'd0 : digit_ok_r) | commit_s;
  end

  // Frame FSM next-state
  always_comb begin
    state_n_s = ST_COLLECT;
    case (state_r)
      ST_COLLECT: state_n_s = (ok_n_s == 6'h3F) ? ST_DONE : ST_COLLECT;
      ST_DONE:    state_n_s = ST_COLLECT;
      default:    state_n_s = ST_COLLECT;
    endcase
  end

  // State registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_r[i] <= 4'd0;
        cnt_r[i]  <= 2'd0;
      end
      digits_r      <= 24'h000000;
      digit_ok_r    <= 6'd0;
      frame_done_r  <= 1'b0;
      err_pattern_r <= 1'b0;
      err_sel_r     <= 1'b0;
      state_r       <= ST_COLLECT;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_r[i] <= cand_n_s[i];
        cnt_r[i]  <= cnt_n_s[i];
      end
      digits_r      <= digits_n_s;
      digit_ok_r    <= ok_n_s;
      frame_done_r  <= (state_r == ST_DONE);
      err_pattern_r <= sample_s && !pat_valid_s;
      err_sel_r     <= seg_valid && !onehot_s;
      state_r       <= state_n_s;
    end
  end

  assign digits      = digits_r;
  assign digit_ok    = digit_ok_r;
  assign frame_done  = frame_done_r;
  assign err_pattern = err_pattern_r;
  assign err_sel     = err_sel_r;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed scoreboard bench for seg7_scan_reader (CONFIRM=2).
module tb_seg7_scan_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [5:0]  dig_sel;
  logic        seg_valid;
  logic [23:0] digits;
  logic [5:0]  digit_ok;
  logic        frame_done;
  logic        err_pattern;
  logic        err_sel;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [23:0] d;
    logic [5:0]  ok;
    logic        ep;
    logic        es;
    logic        fd;
  } exp_t;

  exp_t sb_q[$];

  logic [23:0] e_d;
  logic [5:0]  e_ok;
  logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0]  pats [6] = '{7'h79, 7'h00, 7'h46, 7'h30, 7'h08, 7'h12};
  logic [23:0] target = 24'h5A3C81;

  seg7_scan_reader #(.CONFIRM(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .seg_valid   (seg_valid),
    .digits      (digits),
    .digit_ok    (digit_ok),
    .frame_done  (frame_done),
    .err_pattern (err_pattern),
    .err_sel     (err_sel)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string what, input logic [23:0] got, input logic [23:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, got, want);
    end
  endtask

  task automatic push(input string tag, input logic ep, input logic es, input logic fd);
    exp_t e;
    e.tag = tag; e.d = e_d; e.ok = e_ok; e.ep = ep; e.es = es; e.fd = fd;
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      cmp(e.tag, "digits",      digits,              e.d);
      cmp(e.tag, "digit_ok",    {18'd0, digit_ok},   {18'd0, e.ok});
      cmp(e.tag, "err_pattern", {23'd0, err_pattern}, {23'd0, e.ep});
      cmp(e.tag, "err_sel",     {23'd0, err_sel},    {23'd0, e.es});
      cmp(e.tag, "frame_done",  {23'd0, frame_done}, {23'd0, e.fd});
    end
  endtask

  // One clock: drive a (possibly idle) strobe, expect e_d/e_ok plus given pulses
  task automatic step(input logic v, input logic [5:0] sel, input logic [6:0] seg,
                      input logic ep, input logic es, input logic fd, input string tag);
    seg_valid = v;
    dig_sel   = sel;
    seg_in    = seg;
    push(tag, ep, es, fd);
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    dig_sel   = 6'd0;
    seg_in    = 7'h7F;
    check_pop();
  endtask

  initial begin
    logic [5:0] sel;
    rst = 1'b1; seg_valid = 1'b0; dig_sel = 6'd0; seg_in = 7'h7F;
    e_d = 24'h0; e_ok = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 1'b0, 1'b0, 1'b0);
    check_pop();
    rst = 1'b0;

    // Digit0 confirmed on the second identical strobe
    step(1'b1, 6'b000001, 7'h79, 1'b0, 1'b0, 1'b0, "d0_first");
    e_d = 24'h000001; e_ok = 6'b000001;
    step(1'b1, 6'b000001, 7'h79, 1'b0, 1'b0, 1'b0, "d0_commit");

    // Whole decode table through digit3
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 6'b001000, tbl[k], 1'b0, 1'b0, 1'b0, "tbl_first");
      e_d[15:12] = 4'(k);
      e_ok[3] = 1'b1;
      step(1'b1, 6'b001000, tbl[k], 1'b0, 1'b0, 1'b0, "tbl_commit");
    end

    // Error pulses and idle behaviour
    step(1'b1, 6'b000100, 7'h7F, 1'b1, 1'b0, 1'b0, "bad_pat");
    step(1'b0, 6'b000000, 7'h00, 1'b0, 1'b0, 1'b0, "bad_pat_idle");
    step(1'b1, 6'b000011, 7'h79, 1'b0, 1'b1, 1'b0, "two_hot");
    step(1'b1, 6'b000000, 7'h79, 1'b0, 1'b1, 1'b0, "no_sel");
    step(1'b0, 6'b000100, 7'h7F, 1'b0, 1'b0, 1'b0, "no_valid");

    // An invalid pattern clears the pending count
    step(1'b1, 6'b000100, 7'h79, 1'b0, 1'b0, 1'b0, "d2_a");
    step(1'b1, 6'b000100, 7'h7F, 1'b1, 1'b0, 1'b0, "d2_bad");
    step(1'b1, 6'b000100, 7'h79, 1'b0, 1'b0, 1'b0, "d2_b");
    e_d[11:8] = 4'h1; e_ok[2] = 1'b1;
    step(1'b1, 6'b000100, 7'h79, 1'b0, 1'b0, 1'b0, "d2_commit");

    // Clean frame of 24'h5A3C81
    rst = 1'b1;
    #1;
    e_d = 24'h0; e_ok = 6'd0;
    push("reset2", 1'b0, 1'b0, 1'b0);
    check_pop();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) begin
        sel = 6'b000001 << i;
        if (s == 1) begin
          e_d[4*i +: 4] = target[4*i +: 4];
          e_ok[i] = 1'b1;
        end
        step(1'b1, sel, pats[i], 1'b0, 1'b0, 1'b0, "scan");
      end
    end
    e_ok = 6'd0;
    step(1'b0, 6'd0, 7'h7F, 1'b0, 1'b0, 1'b1, "frame_done");
    step(1'b0, 6'd0, 7'h7F, 1'b0, 1'b0, 1'b0, "after_done");

    // Second frame; a commit landing in the DONE cycle opens the next frame
    step(1'b1, 6'b000001, 7'h24, 1'b0, 1'b0, 1'b0, "f2_d0a");
    e_d[3:0] = 4'h2; e_ok[0] = 1'b1;
    step(1'b1, 6'b000001, 7'h24, 1'b0, 1'b0, 1'b0, "f2_d0b");
    step(1'b1, 6'b000001, 7'h30, 1'b0, 1'b0, 1'b0, "f2_d0_pend");
    for (int i = 1; i < 6; i++) begin
      sel = 6'b000001 << i;
      step(1'b1, sel, 7'h40, 1'b0, 1'b0, 1'b0, "f2_first");
      e_d[4*i +: 4] = 4'h0; e_ok[i] = 1'b1;
      step(1'b1, sel, 7'h40, 1'b0, 1'b0, 1'b0, "f2_commit");
    end
    e_d = 24'h000003; e_ok = 6'b000001;
    step(1'b1, 6'b000001, 7'h30, 1'b0, 1'b0, 1'b1, "done_strobe");
    step(1'b0, 6'd0, 7'h7F, 1'b0, 1'b0, 1'b0, "done_strobe_after");

    // Alternating 7/8 on digit1 never commits 8
    step(1'b1, 6'b000010, 7'h78, 1'b0, 1'b0, 1'b0, "d1_7a");
    e_d[7:4] = 4'h7; e_ok[1] = 1'b1;
    step(1'b1, 6'b000010, 7'h78, 1'b0, 1'b0, 1'b0, "d1_7b");
    for (int r = 0; r < 4; r++) begin
      step(1'b1, 6'b000010, 7'h00, 1'b0, 1'b0, 1'b0, "alt_8");
      step(1'b1, 6'b000010, 7'h78, 1'b0, 1'b0, 1'b0, "alt_7");
    end

    // Reset between first and second strobe discards the pending count
    step(1'b1, 6'b010000, 7'h19, 1'b0, 1'b0, 1'b0, "d4_first");
    #2;
    rst = 1'b1;
    #1;
    e_d = 24'h0; e_ok = 6'd0;
    push("reset_mid", 1'b0, 1'b0, 1'b0);
    check_pop();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 6'b010000, 7'h19, 1'b0, 1'b0, 1'b0, "d4_after_rst");
    e_d = 24'h040000; e_ok = 6'b010000;
    step(1'b1, 6'b010000, 7'h19, 1'b0, 1'b0, 1'b0, "d4_commit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 Parameter CONFIRM, default 2, is the number of consecutive identical decodes of one digit needed to commit it; legal range 1..3.
REQ-002 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 seg_in  input  7  active-low segment pattern; bit0=a … bit6=g; 0 = segment lit.
REQ-005 dig_sel  input  6  one-hot, active-high digit select; bit i = display digit i (HEX0..HEX5).
REQ-006 seg_valid  input  1  strobe; seg_in/dig_sel sampled only in cycles where it is high.
REQ-007 digits  output  24  committed nibbles; digits[4i+3:4i] = digit i.
REQ-008 digit_ok  output  6  bit i high once digit i is committed in the current frame.
REQ-009 frame_done  output  1  one-cycle pulse when all six digits are committed.
REQ-010 err_pattern  output  1  one-cycle pulse for a sampled pattern outside the hex table.
REQ-011 err_sel  output  1  one-cycle pulse for a sampled dig_sel that is not one-hot.

Function
REQ-012 Decode table (seg_in hex -> nibble) shall be exactly: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F; every other pattern is invalid.
REQ-013 Sampling happens only in a cycle with seg_valid=1; with seg_valid=0 all state holds and all pulses stay low.
REQ-014 A dig_sel that is zero or has more than one bit set shall pulse err_sel in the next cycle and change no other state.
REQ-015 A valid select with an invalid pattern shall pulse err_pattern in the next cycle and clear digit i's candidate count to 0.
REQ-016 Each digit keeps a 4-bit candidate and a 2-bit count.
REQ-017 When a valid decode equals the candidate, the count increments, saturating at CONFIRM.
REQ-018 When a valid decode differs from the candidate, the candidate is loaded with the new value and the count is set to 1.
REQ-019 When the count reaches CONFIRM, the nibble is written into digits[4i+3:4i] and digit_ok[i] is set, both visible the cycle after the sample.
REQ-020 A committed digit that later decodes to a different value shall restart confirmation per REQ-018; digits keeps the old nibble and digit_ok[i] stays set until the new value is confirmed.
REQ-021 FSM states: COLLECT, DONE.
  - COLLECT -> DONE when digit_ok becomes 6'b111111 on a clock edge.
  - DONE asserts frame_done for exactly that one cycle, clears digit_ok to 0, keeps digits, and returns to COLLECT.
REQ-022 In the DONE cycle a strobe is still processed. Its commit sets digit_ok for the new frame and is not lost.
REQ-023 Latency is one cycle from a sample to digits, digit_ok and error pulses; frame_done rises one cycle after the final digit_ok bit sets.
REQ-024 At most one of err_pattern and err_sel is high in any cycle.

Reset
REQ-025 Reset shall immediately force: digits=24'h000000, digit_ok=0, all candidates=0, all counts=0, frame_done=0, err_pattern=0, err_sel=0, FSM=COLLECT.
REQ-026 Reset asserted mid-frame discards partial confirmation. After release, the first strobe is treated as a fresh sample.

Structure
REQ-027 The shared package holds:
  - the 16-entry pattern constants;
  - the FSM state encoding;
  - NUM_DIGITS=6.
REQ-028 One combinational sub-module, seg7_to_hex (pattern in; nibble and valid out), implements REQ-012. It is instantiated once, on seg_in.

Verification
REQ-029 Reset, then strobe digit0 with 0x79 twice (CONFIRM=2) -> after the second strobe digits[3:0]=1 and digit_ok=6'b000001; after the first strobe digit_ok=0.
REQ-030 Strobe each of the 16 table patterns twice on digit3 -> digits[15:12] equals the table nibble each time; no error pulse.
REQ-031 Strobe digit2 with 0x7F -> err_pattern pulses one cycle; digit_ok unchanged. Then strobe dig_sel=6'b000011 -> err_sel pulses; no state change.
REQ-032 Scan 6 digits x 2 scans for value 24'h5A3C81 -> digits=24'h5A3C81 and one frame_done pulse. The next cycle digit_ok=0 and digits is held.
REQ-033 Commit digit1=7 (0x78), then alternate 0x78/0x00 on digit1 -> digits[7:4] stays 7 and is never 8.
REQ-034 Assert Reset between the first and second strobe of a digit -> outputs go to reset values immediately. After release, one strobe does not commit the digit.
